// File: rtl/cache_defs.sv
// Shared definitions for the direct-mapped data cache: address-field widths,
// default geometry and the controller state encoding.
package cache_defs;

  localparam int WORD_W         = 32;
  localparam int DEF_NUM_LINES  = 8;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_CNT_W      = 16;

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // The two extra offset bits select the byte within a 32-bit word.
  function automatic int off_width(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int tag_width(input int num_lines, input int line_words);
    return 32 - off_width(line_words) - idx_width(num_lines);
  endfunction

  localparam int DEF_IDX_W  = idx_width(DEF_NUM_LINES);
  localparam int DEF_OFF_W  = off_width(DEF_LINE_WORDS);
  localparam int DEF_TAG_W  = tag_width(DEF_NUM_LINES, DEF_LINE_WORDS);
  localparam int DEF_LINE_W = WORD_W * DEF_LINE_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FILL
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache: asynchronous read by index,
// one synchronous write port that either fills a whole line or byte-merges one word.
module dcache_array
  import cache_defs::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic [IDX_W-1:0]               idx,
  input  logic                           fill_en,
  input  logic [TAG_W-1:0]               fill_tag,
  input  logic [WORD_W*LINE_WORDS-1:0]   fill_line,
  input  logic                           word_en,
  input  logic [$clog2(LINE_WORDS)-1:0]  word_sel,
  input  logic [3:0]                     word_be,
  input  logic [WORD_W-1:0]              word_data,
  output logic                           rd_valid,
  output logic                           rd_dirty,
  output logic [TAG_W-1:0]               rd_tag,
  output logic [WORD_W*LINE_WORDS-1:0]   rd_line
);

  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // A store with no byte enables leaves the dirty bit untouched.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (word_en && (|word_be)) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTn) begin
      if (fill_en) begin
        tag_mem[idx]  <= fill_tag;
        data_mem[idx] <= fill_line;
      end else if (word_en) begin
        for (int b = 0; b < 4; b++) begin
          if (word_be[b]) begin
            data_mem[idx][word_sel*WORD_W + b*8 +: 8] <= word_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_line  = data_mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: lookup FSM,
// registered line-transfer interface to main memory, hit/miss counters.
module dcache_ctrl
  import cache_defs::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [3:0]                    BE,
  input  logic [31:0]                   Addr,
  input  logic [31:0]                   WData,
  output logic [31:0]                   RData,
  output logic                          Ready,
  output logic                          Stall,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [WORD_W*LINE_WORDS-1:0]  mem_wdata,
  input  logic                          mem_ack,
  input  logic [WORD_W*LINE_WORDS-1:0]  mem_rdata,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);

  localparam int IDX_W  = idx_width(NUM_LINES);
  localparam int OFF_W  = off_width(LINE_WORDS);
  localparam int TAG_W  = tag_width(NUM_LINES, LINE_WORDS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]  fill_q, fill_d;
  logic               refill_q, refill_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   addr_tag;
  logic [IDX_W-1:0]   addr_idx;
  logic [WSEL_W-1:0]  addr_word;
  logic               arr_valid, arr_dirty;
  logic [TAG_W-1:0]   arr_tag;
  logic [LINE_W-1:0]  arr_line;
  logic               access, hit, ready, fill_en, word_en;
  logic               unused_addr_bits;

  assign addr_tag         = Addr[31 -: TAG_W];
  assign addr_idx         = Addr[OFF_W +: IDX_W];
  assign addr_word        = Addr[2 +: WSEL_W];
  assign unused_addr_bits = ^Addr[1:0];
  assign access           = MemRead | MemWrite;
  assign hit              = arr_valid && (arr_tag == addr_tag);

  dcache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .idx       (addr_idx),
    .fill_en   (fill_en),
    .fill_tag  (addr_tag),
    .fill_line (fill_q),
    .word_en   (word_en),
    .word_sel  (addr_word),
    .word_be   (BE),
    .word_data (WData),
    .rd_valid  (arr_valid),
    .rd_dirty  (arr_dirty),
    .rd_tag    (arr_tag),
    .rd_line   (arr_line)
  );

  // refill_q marks the lookup that follows a fill, so that access is counted
  // only once (as the original miss) rather than again as a hit.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_d      = fill_q;
    refill_d    = refill_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ready       = 1'b0;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          ready    = 1'b1;
          word_en  = MemWrite;
          refill_d = 1'b0;
          state_d  = IDLE;
          if (!refill_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          mem_req_d  = 1'b1;
          if (arr_valid && arr_dirty) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {arr_tag, addr_idx, {OFF_W{1'b0}}};
            mem_wdata_d = arr_line;
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {addr_tag, addr_idx, {OFF_W{1'b0}}};
            state_d    = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ALLOCATE;
        end
      end
      // Entered with mem_req low only after a write-back; that cycle is the gap.
      ALLOCATE: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_tag, addr_idx, {OFF_W{1'b0}}};
        end else if (mem_ack) begin
          fill_d    = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        fill_en  = 1'b1;
        refill_d = 1'b1;
        state_d  = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
      refill_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_q      <= fill_d;
      refill_q    <= refill_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign Ready     = ready;
  assign RData     = ready ? arr_line[addr_word*WORD_W +: WORD_W] : 32'h0;
  assign Stall     = access & ~ready;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
